// File: rtl/check_move_pkg.sv
// Shared types and helpers for the single-move checker.
//   state_e  : round FSM encoding (IDLE, WAIT)
//   result_e : 2-bit outcome register, decoded to correct/wrong/timeout flags
//   is_one_hot : true when exactly one bit of a (zero-extended) vector is set
package check_move_pkg;

   typedef enum logic {
      IDLE,
      WAIT
   } state_e;

   typedef enum logic [1:0] {
      RES_NONE    = 2'd0,
      RES_CORRECT = 2'd1,
      RES_WRONG   = 2'd2,
      RES_TIMEOUT = 2'd3
   } result_e;

   // Callers zero-extend their vector to 64 bits; targets wider than that are not supported.
   function automatic logic is_one_hot(input logic [63:0] v);
      return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
   endfunction

endpackage

// File: rtl/check_move_gen_if.sv
// Round handshake between the move generator / round FSM (master) and the checker (slave).
//   start, move, window : round arming request
//   ready               : checker idle, start will be accepted
//   done                : one-cycle outcome strobe
//   correct/wrong/timeout : outcome flags, held until the next accepted start
interface check_move_gen_if #(
   parameter int unsigned N_SW  = 8,
   parameter int unsigned N_BTN = 5,
   parameter int unsigned TW    = 29
);
   logic                    start;
   logic [N_SW+N_BTN-1:0]   move;
   logic [TW-1:0]           window;
   logic                    ready;
   logic                    done;
   logic                    correct;
   logic                    wrong;
   logic                    timeout;

   modport master (
      output start, move, window,
      input  ready, done, correct, wrong, timeout
   );

   modport slave (
      input  start, move, window,
      output ready, done, correct, wrong, timeout
   );
endinterface

// File: rtl/move_event_det.sv
// Input event detector over a W-bit pin vector.
//   clk, rst : clock, synchronous active-high reset
//   din      : raw pin vector
//   upd      : load the previous-value register from the current sample
//   ev       : per-bit event; rising edge where RISE_MASK=1, any toggle where RISE_MASK=0
// Build option CHECK_MOVE_GEN_SYNC_EN inserts a 2-flop synchronizer ahead of the edge logic.
module move_event_det #(
   parameter int unsigned     W         = 13,
   parameter logic [W-1:0]    RISE_MASK = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         upd,
   output logic [W-1:0] ev
);

   logic [W-1:0] cur;
   logic [W-1:0] prev_q;

`ifdef CHECK_MOVE_GEN_SYNC_EN
   logic [W-1:0] sync1_q;
   logic [W-1:0] sync2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
      end
   end

   assign cur = sync2_q;
`else
   assign cur = din;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= '0;
      end else if (upd) begin
         prev_q <= cur;
      end
   end

   assign ev = ((cur & ~prev_q) & RISE_MASK) | ((cur ^ prev_q) & ~RISE_MASK);

endmodule

// File: rtl/check_move_gen.sv
// Single-move checker: arms one one-hot target per round and reports correct, wrong or timeout.
//   clk, rst : clock, synchronous active-high reset
//   bus      : check_move_gen_if slave (start/move/window in; ready/done/flags out)
//   sw, btn  : board switches (toggle events) and buttons (rising-edge events)
// Build option CHECK_MOVE_GEN_SYNC_EN: synchronize sw/btn before edge detection.
module check_move_gen
   import check_move_pkg::*;
#(
   parameter int unsigned N_SW  = 8,
   parameter int unsigned N_BTN = 5,
   parameter int unsigned TW    = 29
) (
   input  logic              clk,
   input  logic              rst,
   check_move_gen_if.slave   bus,
   input  logic [N_SW-1:0]   sw,
   input  logic [N_BTN-1:0]  btn
);

   localparam int unsigned NW = N_SW + N_BTN;
   // Buttons count on press only; switches count on either direction.
   localparam logic [NW-1:0] RISE_MASK = {{N_SW{1'b0}}, {N_BTN{1'b1}}};

   state_e          state_q, state_d;
   result_e         res_q, res_d;
   logic [NW-1:0]   move_q, move_d;
   logic [TW-1:0]   cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            upd;
   logic [NW-1:0]   ev;

   move_event_det #(
      .W         (NW),
      .RISE_MASK (RISE_MASK)
   ) u_det (
      .clk (clk),
      .rst (rst),
      .din ({sw, btn}),
      .upd (upd),
      .ev  (ev)
   );

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      move_d  = move_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      upd     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               move_d  = bus.move;
               cnt_d   = (bus.window == '0) ? TW'(1) : bus.window;
               res_d   = RES_NONE;
               upd     = 1'b1; // snapshot so held buttons / preset switches don't count
               state_d = WAIT;
            end
         end
         WAIT: begin
            upd = 1'b1;
            if (!is_one_hot(64'(move_q))) begin
               res_d = RES_WRONG;
            end else if ((ev & move_q) != '0) begin
               res_d = RES_CORRECT;
            end else if ((ev & ~move_q) != '0) begin
               res_d = RES_WRONG;
            end else if (cnt_q == TW'(1)) begin
               res_d = RES_TIMEOUT;
            end else begin
               cnt_d = cnt_q - TW'(1);
            end
            if (res_d != RES_NONE) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         res_q   <= RES_NONE;
         move_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         move_q  <= move_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign bus.ready   = (state_q == IDLE);
   assign bus.done    = done_q;
   assign bus.correct = (res_q == RES_CORRECT);
   assign bus.wrong   = (res_q == RES_WRONG);
   assign bus.timeout = (res_q == RES_TIMEOUT);

endmodule

// File: tb/tb_check_move_gen.sv
// Directed bench for check_move_gen with a round-level reference model and per-cycle compare.
module tb_check_move_gen;

   localparam int unsigned N_SW  = 8;
   localparam int unsigned N_BTN = 5;
   localparam int unsigned TW    = 29;
   localparam int unsigned NW    = N_SW + N_BTN;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N_SW-1:0]  sw  = '0;
   logic [N_BTN-1:0] btn = '0;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   check_move_gen_if #(.N_SW(N_SW), .N_BTN(N_BTN), .TW(TW)) bus ();

   check_move_gen #(.N_SW(N_SW), .N_BTN(N_BTN), .TW(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .sw  (sw),
      .btn (btn)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model: one round at a time ----------------
   bit            m_armed = 1'b0;
   bit            m_done  = 1'b0;
   int            m_res   = 0;      // 0 none, 1 correct, 2 wrong, 3 timeout
   int            m_left  = 0;      // evaluation edges remaining in the window
   logic [NW-1:0] m_move  = '0;
   logic [NW-1:0] m_prev  = '0;
   logic [NW-1:0] m_s1    = '0;
   logic [NW-1:0] m_s2    = '0;

   always @(posedge clk) begin
      logic [NW-1:0] pins;
      logic [NW-1:0] evs;
      int            res;
`ifdef CHECK_MOVE_GEN_SYNC_EN
      pins = m_s2;
      m_s2 = m_s1;
      m_s1 = {sw, btn};
`else
      pins = {sw, btn};
`endif
      m_done = 1'b0;
      if (rst) begin
         m_armed = 1'b0;
         m_res   = 0;
         m_prev  = '0;
         m_s1    = '0;
         m_s2    = '0;
      end else if (!m_armed) begin
         if (bus.start) begin
            m_armed = 1'b1;
            m_move  = bus.move;
            m_left  = (bus.window == '0) ? 1 : int'(bus.window);
            m_res   = 0;
            m_prev  = pins;
         end
      end else begin
         for (int i = 0; i < int'(NW); i++) begin
            if (i < int'(N_BTN)) evs[i] = pins[i] && !m_prev[i];
            else                 evs[i] = pins[i] != m_prev[i];
         end
         m_prev = pins;
         res = 0;
         if ($countones(m_move) != 1)     res = 2;
         else if ((evs & m_move) != '0)   res = 1;
         else if ((evs & ~m_move) != '0)  res = 2;
         else if (m_left == 1)            res = 3;
         else                             m_left--;
         if (res != 0) begin
            m_res   = res;
            m_done  = 1'b1;
            m_armed = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check1("ready",   bus.ready,   !m_armed);
         check1("done",    bus.done,    m_done);
         check1("correct", bus.correct, m_res == 1);
         check1("wrong",   bus.wrong,   m_res == 2);
         check1("timeout", bus.timeout, m_res == 3);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives start for exactly one edge (the accept edge).
   task automatic arm(input logic [NW-1:0] mv, input int w);
      bus.start  = 1'b1;
      bus.move   = mv;
      bus.window = TW'(w);
      tick(1);
      bus.start  = 1'b0;
   endtask

   // Edges counted including the accept edge, until done is seen.
   task automatic measure(output int n);
      n = 1;
      while (!bus.done && n < 200) begin
         tick(1);
         n++;
      end
   endtask

   initial begin
      int n;
      bus.start  = 1'b0;
      bus.move   = '0;
      bus.window = '0;

      // Reset
      rst = 1'b1;
      tick(1);
      chk_en = 1'b1;
      tick(1);
      rst = 1'b0;
      check1("rst_ready", bus.ready, 1'b1);
      check1("rst_done", bus.done, 1'b0);
      check1("rst_flags", bus.correct | bus.wrong | bus.timeout, 1'b0);

      // Correct button press at edge 5, held 2 cycles
      arm(13'b1, 20);
      tick(4);
      btn = 5'b00001;
      tick(1);
      check1("btn_ok_done", bus.done, 1'b1);
      check1("btn_ok_correct", bus.correct, 1'b1);
      check1("btn_ok_ready", bus.ready, 1'b1);
      tick(1);
      btn = '0;
      check1("btn_ok_done_drop", bus.done, 1'b0);
      check1("btn_ok_hold", bus.correct, 1'b1);
      tick(2);

      // Wrong button
      arm(13'b1, 20);
      tick(4);
      btn = 5'b00010;
      tick(1);
      check1("btn_wr_wrong", bus.wrong, 1'b1);
      check1("btn_wr_correct", bus.correct, 1'b0);
      check1("btn_wr_done", bus.done, 1'b1);
      btn = '0;
      tick(2);

      // Timeouts
      arm(13'b1, 20);
      measure(n);
      check_int("to_w20_edges", n, 21);
      check1("to_w20_flag", bus.timeout, 1'b1);
      tick(1);
      arm(13'b1, 0);
      measure(n);
      check_int("to_w0_edges", n, 2);
      check1("to_w0_flag", bus.timeout, 1'b1);
      tick(1);

      // Button held through arm, released at edge 3, pressed again at edge 6
      btn = 5'b00001;
      tick(1);
      arm(13'b1, 20);
      tick(2);
      btn = '0;
      tick(3);
      btn = 5'b00001;
      tick(1);
      check1("held_done", bus.done, 1'b1);
      check1("held_correct", bus.correct, 1'b1);
      btn = '0;
      tick(2);

      // Switch toggle (sw[0] from 1 to 0) counts
      sw = 8'hFF;
      tick(1);
      arm(13'b1 << 5, 20);
      tick(2);
      sw = 8'hFE;
      tick(1);
      check1("sw_correct", bus.correct, 1'b1);
      check1("sw_done", bus.done, 1'b1);
      tick(1);

      // Non-one-hot target decides wrong on the first WAIT edge
      arm(13'b11, 20);
      check1("multi_wait", bus.ready, 1'b0);
      tick(1);
      check1("multi_wrong", bus.wrong, 1'b1);
      check1("multi_done", bus.done, 1'b1);
      tick(1);
      arm(13'b0, 20);
      tick(1);
      check1("zero_wrong", bus.wrong, 1'b1);
      tick(1);

      // Target beats a simultaneous wrong event
      arm(13'b1, 20);
      tick(2);
      btn = 5'b00011;
      tick(1);
      check1("simul_correct", bus.correct, 1'b1);
      check1("simul_wrong", bus.wrong, 1'b0);
      btn = '0;
      tick(1);

      // Reset mid-WAIT abandons the round
      arm(13'b1, 20);
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check1("midrst_ready", bus.ready, 1'b1);
      check1("midrst_done", bus.done, 1'b0);
      check1("midrst_flags", bus.correct | bus.wrong | bus.timeout, 1'b0);
      tick(1);

      // start while busy is ignored (target stays btn0)
      arm(13'b1, 10);
      bus.start = 1'b1;
      bus.move  = 13'b10;
      tick(2);
      bus.start = 1'b0;
      btn = 5'b00001;
      tick(1);
      check1("busy_start_correct", bus.correct, 1'b1);
      btn = '0;

      // start in the done cycle is accepted and clears flags
      arm(13'b1, 3);
      check1("b2b_flags_cleared", bus.correct, 1'b0);
      check1("b2b_busy", bus.ready, 1'b0);
      measure(n);
      check_int("b2b_to_edges", n, 4);
      check1("b2b_timeout", bus.timeout, 1'b1);
      tick(3);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/check_move_gen.md
Name: check_move_gen

Overview:
Parametrised successor to the game's single-move checker. One move is armed per round: a one-hot target over N_SW switches and N_BTN buttons, plus a response window in clock cycles. The block detects button rising edges and switch toggles, then reports one of three outcomes: correct, wrong input, or timeout. It sits between the move generator / round FSM and the board's sw/btn pins.

Parameters:
N_SW, 8, number of slide switches
N_BTN, 5, number of push buttons
TW, 29, width of window / countdown counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  arm a round; accepted only while ready=1
move  in  N_SW+N_BTN  one-hot target; bits [N_BTN-1:0]=btn, [N_BTN+N_SW-1:N_BTN]=sw
window  in  TW  response window in cycles; 0 treated as 1
sw  in  N_SW  raw switches
btn  in  N_BTN  raw buttons
ready  out  1  idle, can accept start
done  out  1  one-cycle pulse, outcome valid
correct  out  1  target event seen first
wrong  out  1  non-target event seen, or move not one-hot
timeout  out  1  window expired with no event

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE; ready=1; done=0; correct=wrong=timeout=0; counter=0; input snapshot cleared. Reset overrides everything, including mid-round. A round in progress is abandoned with no done pulse.
- States: IDLE, WAIT.
- IDLE: ready=1. At an edge with start=1:
  - latch move;
  - load cnt = max(window,1);
  - snapshot prev_sw=sw and prev_btn=btn, so a held button or preset switch does not count;
  - clear correct/wrong/timeout;
  - go to WAIT, ready=0.
  - start while ready=0 is ignored.
- WAIT: each edge evaluates events:
  - btn_ev = btn & ~prev_btn (rising edges);
  - sw_ev = sw ^ prev_sw (toggles);
  - ev = {sw_ev, btn_ev};
  - prev regs update every WAIT cycle.
- Priority at one edge:
  1. latched move not one-hot (zero or multi-bit) → wrong, decided on the first WAIT edge.
  2. (ev & move) != 0 → correct. Target beats a simultaneous wrong event.
  3. (ev & ~move) != 0 → wrong.
  4. cnt == 1 → timeout.
  5. otherwise cnt <= cnt-1.
- Deciding edge: set exactly one flag, done=1, state→IDLE, ready=1. done drops on the next edge. Flags hold until the next accepted start or reset.
- Back-to-back rounds: start may be asserted in the cycle where done=1; it is accepted.
- Latency: window=W with no input gives timeout and done exactly W+1 edges after the start-accept edge (1 arm edge + W evaluation edges). An event present at evaluation edge j (1..W) decides at that edge.
- A switch toggled and restored between edges is invisible (sampled design). Button bounce is not filtered here.

Optional Feature:
CHECK_MOVE_GEN_SYNC_EN
- Defined: sw and btn each pass through a 2-flop synchronizer before snapshot and edge logic. Response latency from a pin change rises by 2 cycles. Window counting is unchanged. Synchronizer flops reset to 0.
- Undefined: raw sw/btn used directly; inputs are assumed already synchronous.

Decomposition:
- Package check_move_pkg holds:
  - state encoding (IDLE, WAIT);
  - result constants RES_NONE, RES_CORRECT, RES_WRONG, RES_TIMEOUT, used internally as a 2-bit result register decoded to the three flags;
  - one-hot check function.
- One natural sub-module, move_event_det, parametrised on width. It holds the optional synchronizer, the prev register with load-snapshot, and the rise/toggle outputs. Instantiate it once over the concatenated {sw,btn} vector, with a per-bit mode mask (rise vs toggle).

Test Plan:
- Correct button press: window=20, move=13'b1, start at t0; btn=1 at edge 5 for 2 cycles → correct=1, done pulse at edge 5, ready=1.
- Wrong button: move=13'b1, btn=2 at edge 5 → wrong=1, correct=0, done once.
- Timeout: window=20, move=13'b1, no input → timeout=1, done exactly 21 edges after accept. With window=0 → timeout 2 edges after accept.
- Held button at arm: btn[0] held through start, released at edge 3, pressed again at edge 6 → correct at edge 6 (no event before).
- Switch and invalid move:
  - move=bit5 (sw[0]) with sw starting at 8'hFF; sw[0] cleared → correct (toggle, not level);
  - move=13'b11 → wrong on first WAIT edge;
  - simultaneous btn0 and btn1 rises with move=btn0 → correct.
- Reset and re-arm: rst=1 mid-WAIT → next edge ready=1, all flags 0, no done. start with ready=0 is ignored. start during the done cycle is accepted, and the previous flags are cleared.
